multi_debouncer: RTL and testbench
==================================

// Module: multi_debouncer
// PURPOSE
//  Parametrised N-channel push-button debouncer for the traffic light controller front end.
//  - Each channel: 2-flop synchroniser, then a stability counter on a shared prescaled tick.
//  - Outputs per channel: a clean level, plus single-cycle rise/fall pulses for the FSM.
//  - Optionally detects a long press (e.g. held reprogram button).
// PARAMETERS
//  N_CH          3      number of input channels (>=1)
//  PRESCALE      1000   clk cycles per debounce tick (>=1; 1 = tick every cycle)
//  STABLE_TICKS  20     consecutive ticks the input must differ from clean before clean flips (>=1)
//  RESET_LEVEL   '0     N_CH-bit idle/reset level per channel
//  HOLD_TICKS    2000   ticks of continuous assertion before hold_out fires (HOLD_DETECT_EN only)
// PORTS
//  clk          in   1     system clock
//  sys_reset_n  in   1     synchronous, active-low reset
//  noisy_in     in   N_CH  raw asynchronous button inputs
//  clean_out    out  N_CH  debounced levels
//  rise_out     out  N_CH  1-cycle pulse when clean goes 0->1
//  fall_out     out  N_CH  1-cycle pulse when clean goes 1->0
//  hold_out     out  N_CH  1-cycle pulse on long press (tied 0 without HOLD_DETECT_EN)
// BEHAVIOUR
//  - Reset: single clock, synchronous, active-low; sampled only on the rising clk edge.
//  - While sys_reset_n=0 at a clk edge:
//    - sync flops and clean_out load RESET_LEVEL.
//    - prescaler, stability counters and hold counters clear to 0.
//    - rise/fall/hold outputs are 0.
//    - No edge pulse is ever produced by reset entry or exit, including reset mid-count.
//  - Synchroniser: s[i] = noisy_in[i] delayed 2 clk cycles.
//  - Prescaler: counts 0..PRESCALE-1 and wraps; tick=1 in the cycle the count equals PRESCALE-1.
//  - Channel counter: width $clog2(STABLE_TICKS+1); all channels are independent.
//    - Any cycle with s==clean: cnt<=0, regardless of tick.
//    - s!=clean and tick, cnt<STABLE_TICKS-1: cnt<=cnt+1.
//    - s!=clean and tick, cnt==STABLE_TICKS-1: clean<=s, cnt<=0, and the matching rise/fall pulse is 1 in the next cycle only.
//  - Latency from the s change to the clean change lies in [(STABLE_TICKS-1)*PRESCALE+1, STABLE_TICKS*PRESCALE] cycles.
//    - With PRESCALE=1: exactly 2+STABLE_TICKS cycles from a noisy_in change to clean_out.
//  - Glitch handling:
//    - A glitch shorter than STABLE_TICKS ticks never changes clean.
//    - Any bounce back to the clean level restarts the count from 0.
//  - rise_out and fall_out are never both 1 on the same channel; pulses are registered (no comb path from noisy_in).
// CONFIGURATION
//  HOLD_DETECT_EN defined:
//  - Per-channel hold counter, width $clog2(HOLD_TICKS+1).
//    - Increments on tick while clean != RESET_LEVEL[i]; saturates at HOLD_TICKS.
//    - Clears to 0 when clean returns to RESET_LEVEL[i].
//  - hold_out[i] pulses 1 cycle on the tick where the counter reaches HOLD_TICKS.
//  - At most one hold pulse per press; no retrigger until release.
//  HOLD_DETECT_EN undefined:
//  - hold_out = '0; no hold counters are built; HOLD_TICKS is ignored.
// STRUCTURE
//  - Package debounce_pkg:
//    - default constants DB_PRESCALE_DEF, DB_STABLE_TICKS_DEF, DB_HOLD_TICKS_DEF
//    - function db_cnt_w(n) returning $clog2(n+1)
//  - Sub-module debounce_channel:
//    - contents: sync, stability counter, edge pulses and optional hold counter for one channel.
//    - Generate-instantiated N_CH times.
//    - Fed by one shared prescaler tick kept in multi_debouncer.
// TESTING (N_CH=3, PRESCALE=1, STABLE_TICKS=5, HOLD_TICKS=10, RESET_LEVEL=3'b000)
//  1. Reset: hold sys_reset_n=0 for 3 cycles with noisy_in=3'b111, then release.
//     -> clean_out=000 and rise/fall=0 during reset; clean_out[0] rises 7 cycles after release, with rise_out[0] pulsed once.
//  2. Clean edge: noisy_in[0] 0->1 at cycle 0.
//     -> clean_out[0]=1 at cycle 7; rise_out[0]=1 for exactly 1 cycle; channels 1 and 2 unaffected.
//  3. Bounce: noisy_in[1] toggles 1,0,1,0 every 2 cycles, then stays 1.
//     -> no change until 7 cycles after the last edge; exactly one rise_out[1] pulse.
//  4. Glitch: noisy_in[2]=1 for 4 cycles, then 0.
//     -> clean_out[2] stays 0; no pulses.
//  5. Hold (HOLD_DETECT_EN): noisy_in[0]=1 for 30 cycles.
//     -> hold_out[0] pulses once, 10 cycles after clean rises; no retrigger.
//     -> Release: fall_out[0] pulses once.
//     -> Without the macro: hold_out stays 000 throughout.
//  6. Reset mid-count: noisy_in[0]=1 with cnt=3, then assert sys_reset_n=0 for 1 cycle.
//     -> cnt is cleared and clean_out[0]=0; no fall/rise pulse results from the reset.
//     -> After release, the full 5-tick count restarts.
//  Also: PRESCALE=4 variant.
//     -> Latency is within [17,20] cycles after s changes.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared default constants and counter-width helper for the debouncer.
package debounce_pkg;
  localparam int unsigned DB_PRESCALE_DEF     = 1000;
  localparam int unsigned DB_STABLE_TICKS_DEF = 20;
  localparam int unsigned DB_HOLD_TICKS_DEF   = 2000;

  function automatic int unsigned db_cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one-channel synchroniser, stability counter, edge pulses and optional long-press detect.
// Long-press detection is built only when HOLD_DETECT_EN is defined.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DB_STABLE_TICKS_DEF,
  parameter int unsigned HOLD_TICKS   = DB_HOLD_TICKS_DEF,
  parameter logic        RESET_BIT    = 1'b0
) (
  input  logic clk,
  input  logic sys_reset_n,
  input  logic tick,
  input  logic noisy,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic hold
);
  localparam int unsigned CW = db_cnt_w(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  if (STABLE_TICKS < 1 || HOLD_TICKS < 1) begin : g_bad_cfg
    $error("debounce_channel: STABLE_TICKS and HOLD_TICKS must be >= 1");
  end

  logic [1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic clean_q, clean_d, rise_q, rise_d, fall_q, fall_d, flip;

  always_comb begin
    sync_d  = {sync_q[0], noisy};
    flip    = tick && (sync_q[1] != clean_q) && (cnt_q == CNT_LAST);
    cnt_d   = (sync_q[1] == clean_q || flip) ? '0 : tick ? cnt_q + 1'b1 : cnt_q;
    clean_d = flip ? sync_q[1] : clean_q;
    rise_d  = flip && sync_q[1];
    fall_d  = flip && !sync_q[1];
  end

  always_ff @(posedge clk) begin
    if (!sys_reset_n) begin
      sync_q  <= {2{RESET_BIT}};
      clean_q <= RESET_BIT;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean = clean_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

`ifdef HOLD_DETECT_EN
  localparam int unsigned HW = db_cnt_w(HOLD_TICKS);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic hold_q, hold_d;

  // Saturating at HOLD_MAX keeps a single pulse per press.
  always_comb begin
    hcnt_d = (clean_q == RESET_BIT) ? '0 : (tick && hcnt_q != HOLD_MAX) ? hcnt_q + 1'b1 : hcnt_q;
    hold_d = tick && (clean_q != RESET_BIT) && (hcnt_q == HOLD_MAX - 1'b1);
  end

  always_ff @(posedge clk) begin
    if (!sys_reset_n) begin
      hcnt_q <= '0;
      hold_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      hold_q <= hold_d;
    end
  end

  assign hold = hold_q;
`else
  assign hold = 1'b0;
`endif
endmodule

// File: rtl/multi_debouncer.sv
// multi_debouncer: N-channel push-button debouncer with a shared prescaled tick.
// Define HOLD_DETECT_EN to enable per-channel long-press pulses on hold_out.
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned    N_CH         = 3,
  parameter int unsigned    PRESCALE     = DB_PRESCALE_DEF,
  parameter int unsigned    STABLE_TICKS = DB_STABLE_TICKS_DEF,
  parameter logic [N_CH-1:0] RESET_LEVEL = '0,
  parameter int unsigned    HOLD_TICKS   = DB_HOLD_TICKS_DEF
) (
  input  logic            clk,
  input  logic            sys_reset_n,
  input  logic [N_CH-1:0] noisy_in,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_out,
  output logic [N_CH-1:0] fall_out,
  output logic [N_CH-1:0] hold_out
);
  localparam int unsigned PW = db_cnt_w(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  if (N_CH < 1 || PRESCALE < 1) begin : g_bad_cfg
    $error("multi_debouncer: N_CH and PRESCALE must be >= 1");
  end

  logic [PW-1:0] pre_q, pre_d;
  logic tick;

  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!sys_reset_n) pre_q <= '0;
    else pre_q <= pre_d;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS),
      .HOLD_TICKS  (HOLD_TICKS),
      .RESET_BIT   (RESET_LEVEL[i])
    ) u_ch (
      .clk        (clk),
      .sys_reset_n(sys_reset_n),
      .tick       (tick),
      .noisy      (noisy_in[i]),
      .clean      (clean_out[i]),
      .rise       (rise_out[i]),
      .fall       (fall_out[i]),
      .hold       (hold_out[i])
    );
  end
endmodule

// File: tb/tb_multi_debouncer.sv
// tb_multi_debouncer: table vectors, directed corner sequences and random stimulus against a timestamp model.
module tb_multi_debouncer;
  localparam int ST = 5;
  localparam int HT = 10;
`ifdef HOLD_DETECT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic sys_reset_n, rst4_n;
  logic [2:0] noisy_in, clean_out, rise_out, fall_out, hold_out;
  logic [0:0] noisy4, clean4, rise4, fall4, hold4;

  always #5 clk = ~clk;

  multi_debouncer #(.N_CH(3), .PRESCALE(1), .STABLE_TICKS(ST), .RESET_LEVEL(3'b000), .HOLD_TICKS(HT)) dut (
    .clk(clk), .sys_reset_n(sys_reset_n), .noisy_in(noisy_in), .clean_out(clean_out),
    .rise_out(rise_out), .fall_out(fall_out), .hold_out(hold_out));

  multi_debouncer #(.N_CH(1), .PRESCALE(4), .STABLE_TICKS(ST), .RESET_LEVEL(1'b0), .HOLD_TICKS(HT)) dut_p4 (
    .clk(clk), .sys_reset_n(rst4_n), .noisy_in(noisy4), .clean_out(clean4),
    .rise_out(rise4), .fall_out(fall4), .hold_out(hold4));

  int errors = 0, checks = 0, stepno = 0, n = 0;
  logic [2:0] m_s1, m_s2, m_clean, m_rise, m_fall, m_hold;
  int mis_start[3], press_start[3];
  int rise_n[3], fall_n[3], hold_n[3], rise_at[3], hold_at[3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (step %0d)", nm, act, exp, stepno);
    end
  endtask

  // Clean flips once s has differed from clean on ST consecutive edges; hold fires on the HT-th edge of a press.
  task automatic model_edge(input logic rn, input logic [2:0] nz);
    logic [2:0] old_clean;
    n++;
    m_rise = '0; m_fall = '0; m_hold = '0;
    if (!rn) begin
      m_s1 = '0; m_s2 = '0; m_clean = '0;
      for (int i = 0; i < 3; i++) begin mis_start[i] = -1; press_start[i] = -1; end
    end else begin
      old_clean = m_clean;
      for (int i = 0; i < 3; i++) begin
        if (m_s2[i] != m_clean[i]) begin
          if (mis_start[i] < 0) mis_start[i] = n;
          if (n - mis_start[i] + 1 == ST) begin
            m_clean[i] = m_s2[i]; m_rise[i] = m_s2[i]; m_fall[i] = !m_s2[i]; mis_start[i] = -1;
          end
        end else mis_start[i] = -1;
        if (old_clean[i]) begin
          if (press_start[i] < 0) press_start[i] = n;
          if (HOLD_EN && n - press_start[i] + 1 == HT) m_hold[i] = 1'b1;
        end else press_start[i] = -1;
      end
      m_s2 = m_s1; m_s1 = nz;
    end
  endtask

  task automatic clear_events();
    for (int i = 0; i < 3; i++) begin rise_n[i] = 0; fall_n[i] = 0; hold_n[i] = 0; rise_at[i] = -1; hold_at[i] = -1; end
  endtask

  task automatic step(input logic rn, input logic [2:0] nz);
    sys_reset_n = rn; noisy_in = nz;
    @(posedge clk);
    model_edge(rn, nz);
    #1;
    stepno++;
    chk("clean", 32'(clean_out), 32'(m_clean));
    chk("rise", 32'(rise_out), 32'(m_rise));
    chk("fall", 32'(fall_out), 32'(m_fall));
    chk("hold", 32'(hold_out), 32'(m_hold));
    chk("rise_fall_excl", 32'(rise_out & fall_out), 0);
    for (int i = 0; i < 3; i++) begin
      if (rise_out[i] === 1'b1) begin rise_n[i]++; rise_at[i] = stepno; end
      if (fall_out[i] === 1'b1) fall_n[i]++;
      if (hold_out[i] === 1'b1) begin hold_n[i]++; hold_at[i] = stepno; end
    end
  endtask

  task automatic run(input logic rn, input logic [2:0] nz, input int cnt);
    for (int k = 0; k < cnt; k++) step(rn, nz);
  endtask

  typedef struct {
    logic       rn;
    logic [2:0] nz, clean, rise, fall;
  } vec_t;
  vec_t tv[11];

  initial begin
    int t0, lat;
    logic [2:0] lvl;
    logic tgt;
    sys_reset_n = 1'b0; noisy_in = '0; rst4_n = 1'b0; noisy4 = '0;
    for (int k = 0; k < 11; k++)
      tv[k] = '{k >= 3, 3'b111, (k >= 9) ? 3'b111 : 3'b000, (k == 9) ? 3'b111 : 3'b000, 3'b000};

    // reset with inputs high, then release: all channels rise on the 7th edge after release
    clear_events();
    for (int k = 0; k < 11; k++) begin
      step(tv[k].rn, tv[k].nz);
      chk("tv_clean", 32'(clean_out), 32'(tv[k].clean));
      chk("tv_rise", 32'(rise_out), 32'(tv[k].rise));
      chk("tv_fall", 32'(fall_out), 32'(tv[k].fall));
    end
    chk("reset_rise_count", rise_n[0], 1);

    // clean edge on channel 0
    run(1'b1, 3'b000, 12);
    clear_events(); t0 = stepno;
    run(1'b1, 3'b001, 10);
    chk("edge_rise_count", rise_n[0], 1);
    chk("edge_latency", rise_at[0] - t0, 7);
    chk("edge_other_ch", rise_n[1] + rise_n[2] + fall_n[1] + fall_n[2], 0);

    // bounce on channel 1
    clear_events();
    run(1'b1, 3'b011, 2); run(1'b1, 3'b001, 2); run(1'b1, 3'b011, 2); run(1'b1, 3'b001, 2);
    t0 = stepno;
    run(1'b1, 3'b011, 10);
    chk("bounce_rise_count", rise_n[1], 1);
    chk("bounce_latency", rise_at[1] - t0, 7);

    // short glitch on channel 2
    clear_events();
    run(1'b1, 3'b111, 4); run(1'b1, 3'b011, 12);
    chk("glitch_pulses", rise_n[2] + fall_n[2], 0);
    chk("glitch_clean", 32'(clean_out[2]), 0);

    // long press on channel 0
    run(1'b1, 3'b000, 12);
    clear_events();
    run(1'b1, 3'b001, 30);
    chk("hold_count", hold_n[0], HOLD_EN ? 1 : 0);
    chk("hold_gap", hold_n[0] == 0 ? -1 : hold_at[0] - rise_at[0], HOLD_EN ? 10 : -1);
    clear_events();
    run(1'b1, 3'b000, 10);
    chk("release_fall_count", fall_n[0], 1);
    chk("release_hold_count", hold_n[0], 0);

    // reset in the middle of a count
    clear_events();
    run(1'b1, 3'b001, 5);
    step(1'b0, 3'b001);
    chk("midreset_pulses", rise_n[0] + fall_n[0], 0);
    chk("midreset_clean", 32'(clean_out[0]), 0);
    clear_events(); t0 = stepno;
    run(1'b1, 3'b001, 10);
    chk("midreset_rise_count", rise_n[0], 1);
    chk("midreset_latency", rise_at[0] - t0, 7);

    // random stimulus with occasional resets
    lvl = '0;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, (k / 100) % 2 ? 2 : 9) == 0) lvl[i] = ~lvl[i];
      step($urandom_range(0, 199) != 0, lvl);
    end

    // PRESCALE=4: latency from input change at various prescaler phases
    rst4_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst4_n = 1'b1;
    repeat (30) @(posedge clk);
    for (int t = 0; t < 8; t++) begin
      repeat ($urandom_range(0, 7)) @(posedge clk);
      #1;
      tgt = ~clean4[0];
      noisy4 = tgt;
      lat = 0;
      while (lat < 60) begin
        @(posedge clk); #1; lat++;
        if (clean4[0] === tgt) break;
      end
      chk("p4_latency_in_range", (lat >= 19 && lat <= 22), 1);
      repeat (3) @(posedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
